uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Frame-sequencing FSM for the UART receiver datapath. It detects the start edge, runs the per-bit oversampling edge counter and the data bit counter, and issues one-cycle enables to the bit sampler, deserializer, start/parity/stop checkers. It also collects checker error flags and emits the per-frame data_valid and error pulses toward the RX clock-domain consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9 supported)
PRESCALE_W, 6, width of prescale input and edge counter

Ports:
CLK  input  1  receiver oversampling clock
RST  input  1  reset
RX_IN  input  1  serial line (already synchronized; idle high)
PAR_EN  input  1  parity bit present in frame
prescale  input  PRESCALE_W  oversampling ratio: 8, 16 or 32
strt_glitch  input  1  registered start-check result (1 = glitch)
par_err  input  1  registered parity-check result
stp_err  input  1  registered stop-check result
dat_samp_en  output  1  sampler enable, high while frame in progress
edge_cnt  output  PRESCALE_W  current oversample edge index within bit
strt_chk_en  output  1  start checker enable pulse
deser_en  output  1  deserializer shift pulse
par_chk_en  output  1  parity checker enable pulse
stp_chk_en  output  1  stop checker enable pulse
data_valid  output  1  one-cycle pulse: frame received without error
frame_err  output  1  one-cycle pulse: stop bit error
parity_err  output  1  one-cycle pulse: parity error
busy  output  1  high whenever state != IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- RST high at a CLK edge: state=IDLE, edge_cnt=0, bit_cnt=0, latched config cleared, all outputs 0. Applies mid-frame; frame is discarded and no pulses are issued.
- Config latch: on IDLE->START, prescale and PAR_EN are latched and held for the whole frame. A prescale value other than 8/16/32 is latched as 8.
- Derived edges: P = latched prescale, LAST = P-1, CHK = P/2+2. These are sampler majority-complete points (6/10/18).
- edge_cnt counts 0..LAST within each bit, wraps to 0 at LAST, and is held at 0 in IDLE.
- States:
  - IDLE: RX_IN==0 -> START. The detection cycle counts as edge 0, so edge_cnt=1 on entry.
  - START: strt_chk_en=1 for exactly the cycle edge_cnt==CHK. At edge_cnt==LAST: strt_glitch=1 -> IDLE (no error pulse); else -> DATA with bit_cnt=0.
  - DATA: deser_en=1 for the cycle edge_cnt==CHK. At edge_cnt==LAST: bit_cnt increments. If bit_cnt==DATA_WIDTH-1, go to PARITY when PAR_EN=1, else STOP.
  - PARITY: par_chk_en=1 at CHK. At LAST: par_err is captured into an internal flag, then -> STOP.
  - STOP: stp_chk_en=1 at CHK. At LAST: -> IDLE, and the following outputs are registered for exactly one cycle:
    - data_valid = !stp_err & !par_flag
    - frame_err = stp_err
    - parity_err = par_flag
- Checker results are sampled only at LAST (>= CHK+1 for every legal P), so each checker's one-cycle registration latency is always covered.
- par_flag is cleared on IDLE->START. It is never set when PAR_EN=0.
- dat_samp_en = busy = (state != IDLE), registered with state.
- All enable pulses are exactly one cycle wide, exactly once per bit, and never asserted in IDLE.
- Back-to-back frames: the first IDLE cycle after STOP may detect the next start bit (RX_IN==0) immediately. No idle gap is required beyond the stop bit.
- RX_IN is ignored in all states except IDLE. The controller relies on the checkers for line content.
- Every flop uses a synchronous reset. There are no combinational paths from inputs to outputs except none; all outputs are registered.

Test Plan:
- Clean frame: P=8, PAR_EN=0, data 0xA5, stop=1.
  - deser_en pulses 8 times, 8 CLK apart.
  - data_valid=1 for one cycle 80 cycles after the falling edge; frame_err=parity_err=0.
- Parity frame: P=16, PAR_EN=1, data 0x3C, even parity.
  - One par_chk_en pulse at edge 10 of bit 9.
  - data_valid pulse at cycle 176.
  - Repeat with par_err forced 1 -> parity_err=1, data_valid=0.
- Stop error: P=8, stop bit driven 0 (stp_err=1).
  - frame_err=1 for one cycle, data_valid=0.
  - FSM back in IDLE, busy=0.
- Start glitch: RX_IN low for 2 cycles only (strt_glitch=1 at LAST).
  - Return to IDLE after 8 cycles.
  - No deser_en, data_valid, or error pulses.
- Reset mid-frame: RST=1 for one cycle during DATA bit 4.
  - Next edge: state IDLE, edge_cnt=0, all outputs 0.
  - A following clean frame (0x5A) completes with data_valid=1.
- Back-to-back and illegal prescale:
  - Two frames with no idle gap at P=32 -> two data_valid pulses, 320 cycles apart.
  - prescale=12 -> frame timed as P=8.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing FSM for the UART receiver: start detection, oversample/bit
// counting, one-cycle checker/deserializer enables and per-frame result pulses.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  strt_glitch,
   input  logic                  par_err,
   input  logic                  stp_err,
   output logic                  dat_samp_en,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic                  strt_chk_en,
   output logic                  deser_en,
   output logic                  par_chk_en,
   output logic                  stp_chk_en,
   output logic                  data_valid,
   output logic                  frame_err,
   output logic                  parity_err,
   output logic                  busy
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                  state, state_n;
   logic [PRESCALE_W-1:0]   edge_n, p_lat, p_lat_n, last_e, chk_n;
   logic [BIT_W-1:0]        bit_cnt, bit_n;
   logic                    par_en_lat, par_en_n, par_flag, par_flag_n;
   logic                    at_last;
   logic                    strt_n, deser_n, par_n, stp_n, dv_n, fe_n, pe_n;

   // Unsupported ratios fall back to the slowest-to-break 8x timing.
   function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
      if (p == PRESCALE_W'(8) || p == PRESCALE_W'(16) || p == PRESCALE_W'(32))
         return p;
      return PRESCALE_W'(8);
   endfunction

   assign last_e  = p_lat - PRESCALE_W'(1);
   assign at_last = (edge_cnt == last_e);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         edge_cnt    <= '0;
         bit_cnt     <= '0;
         p_lat       <= '0;
         par_en_lat  <= 1'b0;
         par_flag    <= 1'b0;
         strt_chk_en <= 1'b0;
         deser_en    <= 1'b0;
         par_chk_en  <= 1'b0;
         stp_chk_en  <= 1'b0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         busy        <= 1'b0;
         dat_samp_en <= 1'b0;
      end else begin
         state       <= state_n;
         edge_cnt    <= edge_n;
         bit_cnt     <= bit_n;
         p_lat       <= p_lat_n;
         par_en_lat  <= par_en_n;
         par_flag    <= par_flag_n;
         strt_chk_en <= strt_n;
         deser_en    <= deser_n;
         par_chk_en  <= par_n;
         stp_chk_en  <= stp_n;
         data_valid  <= dv_n;
         frame_err   <= fe_n;
         parity_err  <= pe_n;
         busy        <= (state_n != IDLE);
         dat_samp_en <= (state_n != IDLE);
      end
   end

   always_comb begin
      state_n    = state;
      edge_n     = at_last ? '0 : edge_cnt + PRESCALE_W'(1);
      bit_n      = bit_cnt;
      p_lat_n    = p_lat;
      par_en_n   = par_en_lat;
      par_flag_n = par_flag;
      case (state)
         IDLE: begin
            edge_n = '0;
            if (!RX_IN) begin
               // The detection cycle is edge 0 of the start bit.
               state_n    = START;
               edge_n     = PRESCALE_W'(1);
               bit_n      = '0;
               p_lat_n    = legal_prescale(prescale);
               par_en_n   = PAR_EN;
               par_flag_n = 1'b0;
            end
         end
         START: begin
            if (at_last) begin
               state_n = strt_glitch ? IDLE : DATA;
               bit_n   = '0;
            end
         end
         DATA: begin
            if (at_last) begin
               if (bit_cnt == BIT_W'(DATA_WIDTH - 1))
                  state_n = par_en_lat ? PARITY : STOP;
               else
                  bit_n = bit_cnt + BIT_W'(1);
            end
         end
         PARITY: begin
            if (at_last) begin
               par_flag_n = par_err;
               state_n    = STOP;
            end
         end
         STOP: begin
            if (at_last) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            edge_n  = '0;
         end
      endcase
   end

   // Enables are registered, so decode them from the next state/edge.
   always_comb begin
      chk_n   = (p_lat_n >> 1) + PRESCALE_W'(2);
      strt_n  = (state_n == START)  && (edge_n == chk_n);
      deser_n = (state_n == DATA)   && (edge_n == chk_n);
      par_n   = (state_n == PARITY) && (edge_n == chk_n);
      stp_n   = (state_n == STOP)   && (edge_n == chk_n);
      dv_n    = 1'b0;
      fe_n    = 1'b0;
      pe_n    = 1'b0;
      if (state == STOP && at_last) begin
         dv_n = !stp_err && !par_flag;
         fe_n = stp_err;
         pe_n = par_flag;
      end
   end

endmodule
